// File: rtl/lfsr_pkg.sv
// Shared LFSR constants: maximal-length Fibonacci tap masks for widths 3..32,
// the default seed and the default 8-bit state type.
package lfsr_pkg;

  localparam int unsigned LFSR_MIN_WIDTH = 3;
  localparam int unsigned LFSR_MAX_WIDTH = 32;

  // Bit i set means state bit i feeds the XOR; the MSB is always part of the mask.
  localparam logic [2:0]  LFSR_TAPS_3  = 3'h6;
  localparam logic [3:0]  LFSR_TAPS_4  = 4'hC;
  localparam logic [4:0]  LFSR_TAPS_5  = 5'h14;
  localparam logic [5:0]  LFSR_TAPS_6  = 6'h30;
  localparam logic [6:0]  LFSR_TAPS_7  = 7'h60;
  localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
  localparam logic [8:0]  LFSR_TAPS_9  = 9'h110;
  localparam logic [9:0]  LFSR_TAPS_10 = 10'h240;
  localparam logic [10:0] LFSR_TAPS_11 = 11'h500;
  localparam logic [11:0] LFSR_TAPS_12 = 12'h829;
  localparam logic [12:0] LFSR_TAPS_13 = 13'h100D;
  localparam logic [13:0] LFSR_TAPS_14 = 14'h2015;
  localparam logic [14:0] LFSR_TAPS_15 = 15'h6000;
  localparam logic [15:0] LFSR_TAPS_16 = 16'hD008;
  localparam logic [16:0] LFSR_TAPS_17 = 17'h12000;
  localparam logic [17:0] LFSR_TAPS_18 = 18'h20400;
  localparam logic [18:0] LFSR_TAPS_19 = 19'h40023;
  localparam logic [19:0] LFSR_TAPS_20 = 20'h90000;
  localparam logic [20:0] LFSR_TAPS_21 = 21'h140000;
  localparam logic [21:0] LFSR_TAPS_22 = 22'h300000;
  localparam logic [22:0] LFSR_TAPS_23 = 23'h420000;
  localparam logic [23:0] LFSR_TAPS_24 = 24'hE10000;
  localparam logic [24:0] LFSR_TAPS_25 = 25'h1200000;
  localparam logic [25:0] LFSR_TAPS_26 = 26'h2000023;
  localparam logic [26:0] LFSR_TAPS_27 = 27'h4000013;
  localparam logic [27:0] LFSR_TAPS_28 = 28'h9000000;
  localparam logic [28:0] LFSR_TAPS_29 = 29'h14000000;
  localparam logic [29:0] LFSR_TAPS_30 = 30'h20000029;
  localparam logic [30:0] LFSR_TAPS_31 = 31'h48000000;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h80200003;

  localparam logic [7:0] LFSR_DEFAULT_SEED = 8'h01;

  typedef logic [7:0] lfsr_state_t;

  function automatic logic [31:0] lfsr_default_taps(input int unsigned width);
    logic [31:0] t;
    t = '0;
    case (width)
      3:  t = 32'(LFSR_TAPS_3);
      4:  t = 32'(LFSR_TAPS_4);
      5:  t = 32'(LFSR_TAPS_5);
      6:  t = 32'(LFSR_TAPS_6);
      7:  t = 32'(LFSR_TAPS_7);
      8:  t = 32'(LFSR_TAPS_8);
      9:  t = 32'(LFSR_TAPS_9);
      10: t = 32'(LFSR_TAPS_10);
      11: t = 32'(LFSR_TAPS_11);
      12: t = 32'(LFSR_TAPS_12);
      13: t = 32'(LFSR_TAPS_13);
      14: t = 32'(LFSR_TAPS_14);
      15: t = 32'(LFSR_TAPS_15);
      16: t = 32'(LFSR_TAPS_16);
      17: t = 32'(LFSR_TAPS_17);
      18: t = 32'(LFSR_TAPS_18);
      19: t = 32'(LFSR_TAPS_19);
      20: t = 32'(LFSR_TAPS_20);
      21: t = 32'(LFSR_TAPS_21);
      22: t = 32'(LFSR_TAPS_22);
      23: t = 32'(LFSR_TAPS_23);
      24: t = 32'(LFSR_TAPS_24);
      25: t = 32'(LFSR_TAPS_25);
      26: t = 32'(LFSR_TAPS_26);
      27: t = 32'(LFSR_TAPS_27);
      28: t = 32'(LFSR_TAPS_28);
      29: t = 32'(LFSR_TAPS_29);
      30: t = 32'(LFSR_TAPS_30);
      31: t = 32'(LFSR_TAPS_31);
      32: t = 32'(LFSR_TAPS_32);
      default: t = '0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/lfsr_feedback.sv
// Combinational feedback bit of a Fibonacci LFSR: XOR-reduce of the tapped state bits.
module lfsr_feedback #(
  parameter int unsigned     WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS = 8'hB8
) (
  input  logic [WIDTH-1:0] q,
  output logic             fb
);

  always_comb begin
    fb = ^(q & TAPS);
  end

endmodule

// File: rtl/lfsr.sv
// Free-running Fibonacci LFSR with zero-state lockup recovery.
// Optional LFSR_SEED_LOAD_EN adds the load/seed_in ports for run-time reseeding.
module lfsr
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(lfsr_default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(LFSR_DEFAULT_SEED)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
`ifdef LFSR_SEED_LOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
`endif
  output logic [WIDTH-1:0] q
);

  if (WIDTH < LFSR_MIN_WIDTH || WIDTH > LFSR_MAX_WIDTH) begin : g_bad_width
    $error("lfsr: WIDTH %0d outside 3..32", WIDTH);
  end
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr: SEED must be nonzero");
  end
  if (!TAPS[WIDTH-1]) begin : g_bad_taps
    $error("lfsr: TAPS must include the MSB");
  end

  logic fb;

  lfsr_feedback #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_feedback (
    .q  (q),
    .fb (fb)
  );

  // Lockup recovery sits above en so an all-zero state never lasts past one edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= SEED;
`ifdef LFSR_SEED_LOAD_EN
    end else if (load) begin
      q <= (seed_in == '0) ? SEED : seed_in;
`endif
    end else if (q == '0) begin
      q <= SEED;
    end else if (en) begin
      q <= {q[WIDTH-2:0], fb};
    end
  end

endmodule

// File: tb/tb_lfsr.sv
// Scoreboard bench for lfsr (default parameters); load tests run when LFSR_SEED_LOAD_EN is defined.
module tb_lfsr;
  import lfsr_pkg::*;

  logic        clk;
  logic        reset;
  logic        en;
  logic [7:0]  q;
`ifdef LFSR_SEED_LOAD_EN
  logic        load;
  logic [7:0]  seed_in;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;

  lfsr_state_t exp_q[$];
  string       tag_q[$];
  lfsr_state_t m;

  lfsr dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
`ifdef LFSR_SEED_LOAD_EN
    .load    (load),
    .seed_in (seed_in),
`endif
    .q       (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // x^8+x^6+x^5+x^4+1: taps at bits 7,5,4,3, shifted in at the LSB
  function automatic lfsr_state_t model_step(input lfsr_state_t s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic lfsr_state_t model_next(input lfsr_state_t s, input logic r, input logic e,
                                             input logic ld, input lfsr_state_t sd);
    if (r)            return 8'h01;
    else if (ld)      return (sd == 8'h00) ? 8'h01 : sd;
    else if (s == 0)  return 8'h01;
    else if (e)       return model_step(s);
    else              return s;
  endfunction

  task automatic drive(input logic r, input logic e, input logic ld, input lfsr_state_t sd);
    reset = r;
    en    = e;
`ifdef LFSR_SEED_LOAD_EN
    load    = ld;
    seed_in = sd;
`endif
  endtask

  task automatic score(input string tag);
    lfsr_state_t want;
    string       t;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      want = exp_q.pop_front();
      t    = tag_q.pop_front();
      check(t, 32'(q), 32'(want));
    end
  endtask

  task automatic cyc(input logic r, input logic e, input logic ld, input lfsr_state_t sd,
                     input string tag);
    @(negedge clk);
    drive(r, e, ld, sd);
    m = model_next(m, r, e, ld, sd);
    exp_q.push_back(m);
    tag_q.push_back(tag);
    score(tag);
  endtask

  logic [7:0] golden [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};
  bit         seen   [256];
  int unsigned distinct;
  bit         zero_seen;

  initial begin
    m = 8'h00;
    drive(1'b0, 1'b0, 1'b0, 8'h00);

    // Reset with en high, then the documented opening sequence.
    cyc(1'b1, 1'b1, 1'b0, 8'h00, "reset");
    check("seq0", 32'(q), 32'(golden[0]));
    for (int i = 1; i < 8; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'h00, "step");
      check($sformatf("seq%0d", i), 32'(q), 32'(golden[i]));
    end

    // Full period from reset.
    cyc(1'b1, 1'b0, 1'b0, 8'h00, "reset2");
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    distinct  = 0;
    zero_seen = 1'b0;
    for (int i = 1; i <= 255; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'h00, "period");
      if (q == 8'h00) zero_seen = 1'b1;
      if (!seen[q]) distinct++;
      seen[q] = 1'b1;
    end
    check("period_wrap", 32'(q), 32'h01);
    check("period_distinct", 32'(distinct), 32'd255);
    check("period_no_zero", 32'(zero_seen), 32'd0);

    // Enable toggle from 01: 1,0,0,1 -> 02,02,02,04.
    cyc(1'b1, 1'b0, 1'b0, 8'h00, "reset3");
    cyc(1'b0, 1'b1, 1'b0, 8'h00, "tog_en1");
    check("tog_a", 32'(q), 32'h02);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, "tog_hold1");
    cyc(1'b0, 1'b0, 1'b0, 8'h00, "tog_hold2");
    check("tog_c", 32'(q), 32'h02);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, "tog_en2");
    check("tog_d", 32'(q), 32'h04);

    // Reset mid-sequence with en high.
    cyc(1'b1, 1'b1, 1'b0, 8'h00, "reset4");
    for (int i = 0; i < 100; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00, "run100");
    cyc(1'b1, 1'b1, 1'b0, 8'h00, "mid_reset");
    check("mid_reset_q", 32'(q), 32'h01);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, "restart");
    check("restart_q", 32'(q), 32'h02);

    // Lockup: force zero state, recovery must happen with en low.
    cyc(1'b0, 1'b1, 1'b0, 8'h00, "pre_force");
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    force dut.q = 8'h00;
    #1;
    release dut.q;
    m = 8'h00;
    m = model_next(m, 1'b0, 1'b0, 1'b0, 8'h00);
    exp_q.push_back(m);
    tag_q.push_back("lockup");
    score("lockup");
    check("lockup_q", 32'(q), 32'h01);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, "lockup_hold");

`ifdef LFSR_SEED_LOAD_EN
    cyc(1'b0, 1'b0, 1'b1, 8'h47, "load47");
    check("load47_q", 32'(q), 32'h47);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, "after_load");
    check("after_load_q", 32'(q), 32'h8E);
    cyc(1'b0, 1'b1, 1'b1, 8'h00, "load_zero");
    check("load_zero_q", 32'(q), 32'h01);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, "pre_both");
    cyc(1'b1, 1'b1, 1'b1, 8'h5A, "reset_and_load");
    check("reset_and_load_q", 32'(q), 32'h01);
`endif

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL timeout: got=running want=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
